// File: rtl/hamming_encoder.sv
// hamming_encoder: serial Hamming(7,4) encoder between two 1-bit FIFOs; define HAMMING_EXT_PARITY_EN for SECDED (8,4)
module hamming_encoder #(
  parameter int BLOCKS_NUMB = 256
) (
  input  logic CLK,
  input  logic RESET,
  input  logic START,
  input  logic FIFO_IN_DATA,
  output logic FIFO_IN_RE,
  input  logic FIFO_IN_EMPTY,
  output logic FIFO_OUT_DATA,
  output logic FIFO_OUT_WE,
  input  logic FIFO_OUT_FULL,
  output logic DONE
);
`ifdef HAMMING_EXT_PARITY_EN
  localparam int CW_LEN = 8;
`else
  localparam int CW_LEN = 7;
`endif
  localparam int BW = $clog2(BLOCKS_NUMB + 1);
  localparam logic [BW-1:0] LAST_BLOCK = BW'(BLOCKS_NUMB - 1);
  localparam logic [2:0] LAST_BIT = 3'(CW_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK_IN, S_READ, S_LATCH, S_ENCODE, S_CHECK_OUT, S_SEND, S_DONE
  } state_t;

  state_t state, nxt;
  logic [2:0] bit_cnt;
  logic [BW-1:0] block_cnt;
  logic [3:0] d;
  logic [CW_LEN-1:0] cw, cw_next;
  logic [6:0] ham;
  logic p1, p2, p3, last_bit, last_block;

  assign p1 = d[0] ^ d[1] ^ d[3];
  assign p2 = d[0] ^ d[2] ^ d[3];
  assign p3 = d[1] ^ d[2] ^ d[3];
  assign ham = {d[3], d[2], d[1], p3, d[0], p2, p1};
`ifdef HAMMING_EXT_PARITY_EN
  assign cw_next = {^ham, ham};
`else
  assign cw_next = ham;
`endif
  assign last_bit = bit_cnt == LAST_BIT;
  assign last_block = block_cnt == LAST_BLOCK;

  assign FIFO_IN_RE = state == S_READ;
  assign FIFO_OUT_WE = state == S_SEND;
  assign FIFO_OUT_DATA = state == S_SEND && cw[bit_cnt];
  assign DONE = state == S_DONE;

  // state register plus the datapath registers each state owns
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= S_IDLE;
      bit_cnt <= '0;
      block_cnt <= '0;
      d <= '0;
      cw <= '0;
    end else begin
      state <= nxt;
      if (state == S_LATCH) begin
        d[bit_cnt[1:0]] <= FIFO_IN_DATA;
        bit_cnt <= bit_cnt == 3'd3 ? 3'd0 : bit_cnt + 3'd1;
      end
      if (state == S_ENCODE) cw <= cw_next;
      if (state == S_SEND) begin
        bit_cnt <= last_bit ? 3'd0 : bit_cnt + 3'd1;
        if (last_bit) block_cnt <= block_cnt + 1'b1;
      end
    end
  end

  // next-state decode; FIFO flags are only looked at in the CHECK states
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:      nxt = START ? S_CHECK_IN : S_IDLE;
      S_CHECK_IN:  nxt = FIFO_IN_EMPTY ? S_CHECK_IN : S_READ;
      S_READ:      nxt = S_LATCH;
      S_LATCH:     nxt = bit_cnt == 3'd3 ? S_ENCODE : S_CHECK_IN;
      S_ENCODE:    nxt = S_CHECK_OUT;
      S_CHECK_OUT: nxt = FIFO_OUT_FULL ? S_CHECK_OUT : S_SEND;
      S_SEND:      nxt = !last_bit ? S_CHECK_OUT : last_block ? S_DONE : S_CHECK_IN;
      S_DONE:      nxt = S_DONE;
      default: begin
        nxt = S_IDLE;
`ifndef SYNTHESIS
        $error("hamming_encoder: illegal state %0d", state);
`endif
      end
    endcase
  end

`ifndef SYNTHESIS
  // announce completion once, on the transition into DONE
  always_ff @(posedge CLK) begin
    if (!RESET && state == S_SEND && nxt == S_DONE) $display("hamming_encoder: DONE at %0t", $time);
  end
`endif
endmodule

// File: tb/tb_hamming_encoder.sv
// tb_hamming_encoder: scoreboard bench with behavioural input/output FIFOs around hamming_encoder
module tb_hamming_encoder;
`ifdef HAMMING_EXT_PARITY_EN
  localparam int CW_LEN = 8;
`else
  localparam int CW_LEN = 7;
`endif
  logic CLK = 0, RESET = 1, START = 0, FIFO_IN_DATA = 0, FIFO_IN_EMPTY = 1, FIFO_OUT_FULL = 0;
  logic FIFO_IN_RE, FIFO_OUT_DATA, FIFO_OUT_WE, DONE;
  logic hold_empty = 0, empty_prev = 1, full_prev = 0;
  bit in_q[$], exp_q[$], got_q[$];
  int re_cnt = 0, viol = 0, checks = 0, failures = 0;

  hamming_encoder #(.BLOCKS_NUMB(3)) dut (
    .CLK(CLK), .RESET(RESET), .START(START),
    .FIFO_IN_DATA(FIFO_IN_DATA), .FIFO_IN_RE(FIFO_IN_RE), .FIFO_IN_EMPTY(FIFO_IN_EMPTY),
    .FIFO_OUT_DATA(FIFO_OUT_DATA), .FIFO_OUT_WE(FIFO_OUT_WE), .FIFO_OUT_FULL(FIFO_OUT_FULL),
    .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  // FIFO models sampled mid-cycle; protocol breaches are tallied in viol
  always @(negedge CLK) begin
    if (FIFO_IN_RE && (empty_prev || in_q.size() == 0 || FIFO_OUT_WE || DONE)) viol++;
    if (FIFO_OUT_WE && full_prev) viol++;
    if (FIFO_IN_RE) begin
      re_cnt++;
      if (in_q.size() > 0) FIFO_IN_DATA = in_q.pop_front();
    end
    if (FIFO_OUT_WE) got_q.push_back(FIFO_OUT_DATA);
    FIFO_IN_EMPTY = hold_empty || in_q.size() == 0;
    empty_prev = FIFO_IN_EMPTY;
    full_prev = FIFO_OUT_FULL;
  end

  function automatic logic [7:0] model(input logic [3:0] v);
    logic [6:0] h;
    h = {v[3], v[2], v[1], v[1] ^ v[2] ^ v[3], v[0], v[0] ^ v[2] ^ v[3], v[0] ^ v[1] ^ v[3]};
    return {^h, h};
  endfunction

  task automatic push_bits(input logic [3:0] v, input bit expect_it, input logic [7:0] cw);
    for (int i = 0; i < 4; i++) in_q.push_back(v[i]);
    if (expect_it) for (int i = 0; i < CW_LEN; i++) exp_q.push_back(cw[i]);
  endtask

  task automatic wait_writes(input int n, input int budget, output bit ok);
    for (int i = 0; i < budget && got_q.size() < n; i++) @(posedge CLK);
    ok = got_q.size() >= n;
    #1;
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #1 RESET = 1;
    START = 0;
    FIFO_OUT_FULL = 0;
    hold_empty = 0;
    repeat (2) @(posedge CLK);
    in_q.delete();
    exp_q.delete();
    got_q.delete();
    viol = 0;
    re_cnt = 0;
    #1 RESET = 0;
  endtask

  task automatic test_reset();
    bit ok;
    int n0, r0;
    do_reset();
    @(negedge CLK);
    checks++;
    if ({FIFO_IN_RE, FIFO_OUT_WE, FIFO_OUT_DATA, DONE} !== 4'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=0000", {FIFO_IN_RE, FIFO_OUT_WE, FIFO_OUT_DATA, DONE});
    end
    push_bits(4'b1101, 0, 8'h0);
    START = 1;
    for (int i = 0; i < 200 && !FIFO_OUT_WE; i++) @(negedge CLK);
    checks++;
    if (FIFO_OUT_WE !== 1'b1) begin
      failures++;
      $display("FAIL reset_reach_send got=%b exp=1", FIFO_OUT_WE);
    end
    RESET = 1;
    START = 0;
    repeat (3) @(posedge CLK);
    #1 RESET = 0;
    n0 = got_q.size();
    r0 = re_cnt;
    @(negedge CLK);
    checks++;
    if ({FIFO_IN_RE, FIFO_OUT_WE, FIFO_OUT_DATA, DONE} !== 4'b0) begin
      failures++;
      $display("FAIL reset_midsend_outputs got=%b exp=0000", {FIFO_IN_RE, FIFO_OUT_WE, FIFO_OUT_DATA, DONE});
    end
    push_bits(4'b1111, 0, 8'h0);
    repeat (40) @(posedge CLK);
    checks++;
    if (got_q.size() != n0 || re_cnt != r0) begin
      failures++;
      $display("FAIL reset_idle_quiet writes=%0d reads=%0d exp writes=%0d reads=%0d", got_q.size(), re_cnt, n0, r0);
    end
    wait_writes(0, 1, ok);
  endtask

  task automatic test_encode();
    bit ok, e, g;
    do_reset();
    push_bits(4'b1101, 1, 8'b01100110);
    push_bits(4'b1111, 1, 8'b11111111);
    push_bits(4'b0001, 1, 8'b10000111);
    START = 1;
    wait_writes(3 * CW_LEN, 400, ok);
    repeat (10) @(posedge CLK);
    checks++;
    if (!ok || got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL encode_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; exp_q.size() > 0 && got_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL encode_bit%0d got=%b exp=%b", i, g, e);
      end
    end
    checks++;
    if (DONE !== 1'b1 || viol != 0) begin
      failures++;
      $display("FAIL encode_done done=%b viol=%0d exp done=1 viol=0", DONE, viol);
    end
  endtask

  task automatic test_full_stall();
    bit ok, e, g;
    int n;
    logic [3:0] v;
    do_reset();
    v = 4'($urandom_range(0, 15));
    push_bits(v, 1, model(v));
    START = 1;
    wait_writes(2, 200, ok);
    FIFO_OUT_FULL = 1;
    n = got_q.size();
    repeat (20) @(posedge CLK);
    checks++;
    if (!ok || got_q.size() != n) begin
      failures++;
      $display("FAIL full_hold writes=%0d exp=%0d", got_q.size(), n);
    end
    #1 FIFO_OUT_FULL = 0;
    wait_writes(CW_LEN, 100, ok);
    repeat (5) @(posedge CLK);
    checks++;
    if (got_q.size() != CW_LEN || viol != 0) begin
      failures++;
      $display("FAIL full_count writes=%0d viol=%0d exp writes=%0d viol=0", got_q.size(), viol, CW_LEN);
    end
    for (int i = 0; exp_q.size() > 0 && got_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL full_bit%0d got=%b exp=%b", i, g, e);
      end
    end
  endtask

  task automatic test_empty_stall();
    bit ok, e, g;
    int r0;
    logic [3:0] v;
    logic [7:0] c;
    do_reset();
    v = 4'($urandom_range(0, 15));
    c = model(v);
    for (int i = 0; i < CW_LEN; i++) exp_q.push_back(c[i]);
    in_q.push_back(v[0]);
    in_q.push_back(v[1]);
    START = 1;
    for (int i = 0; i < 100 && re_cnt < 2; i++) @(posedge CLK);
    #1 hold_empty = 1;
    in_q.push_back(v[2]);
    in_q.push_back(v[3]);
    r0 = re_cnt;
    repeat (15) @(posedge CLK);
    checks++;
    if (r0 != 2 || re_cnt != r0) begin
      failures++;
      $display("FAIL empty_hold reads=%0d exp=2", re_cnt);
    end
    #1 hold_empty = 0;
    wait_writes(CW_LEN, 100, ok);
    checks++;
    if (!ok || viol != 0) begin
      failures++;
      $display("FAIL empty_resume writes=%0d viol=%0d exp writes=%0d viol=0", got_q.size(), viol, CW_LEN);
    end
    for (int i = 0; exp_q.size() > 0 && got_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL empty_bit%0d got=%b exp=%b", i, g, e);
      end
    end
  endtask

  task automatic test_blocks();
    bit e, g;
    logic [3:0] v;
    do_reset();
    for (int b = 0; b < 4; b++) begin
      v = 4'($urandom_range(0, 15));
      push_bits(v, b < 3, model(v));
    end
    START = 1;
    for (int i = 0; i < 400 && DONE !== 1'b1; i++) @(posedge CLK);
    repeat (30) @(posedge CLK);
    #1;
    checks++;
    if (DONE !== 1'b1) begin
      failures++;
      $display("FAIL blocks_done got=%b exp=1", DONE);
    end
    checks++;
    if (got_q.size() != 3 * CW_LEN) begin
      failures++;
      $display("FAIL blocks_count got=%0d exp=%0d", got_q.size(), 3 * CW_LEN);
    end
    checks++;
    if (in_q.size() != 4 || viol != 0) begin
      failures++;
      $display("FAIL blocks_no_read_after_done left=%0d viol=%0d exp left=4 viol=0", in_q.size(), viol);
    end
    for (int i = 0; exp_q.size() > 0 && got_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL blocks_bit%0d got=%b exp=%b", i, g, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_encode();
    test_full_stall();
    test_empty_stall();
    test_blocks();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
